jpeg_block_sequencer: RTL

Parametrised per-block control sequencer for the JPEG encoder pipeline. It drives the stage enables (buffer load, DCT, DCT store, quantise/zigzag row stepping, Huffman start) that the encoder top currently takes as primary inputs. It generalises to multi-component MCUs (Y plus chroma, configurable luma blocks per MCU), configurable DCT and quantiser latencies, and a Huffman-completion handshake with timeout. It sits between the host block feeder and the encoder datapath, handling one 8x8 block at a time.

---
 rtl/jpeg_block_sequencer_if.sv | 38 +++
 rtl/jpeg_block_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_block_sequencer_if.sv
// Block handshake and stage-enable bundle between the host feeder, the sequencer
// and the encoder datapath.
interface jpeg_block_sequencer_if #(
    parameter int unsigned COMP_W = 2
);
    logic              blk_valid;
    logic              blk_last;
    logic              blk_ready;
    logic              huffman_done;
    logic              input_enable;
    logic              dct_enable;
    logic              dct_end_enable;
    logic [7:0]        matrix_row;
    logic              zigzag_input_enable;
    logic              zigzag_enable;
    logic              huffman_start;
    logic              is_luminance;
    logic [COMP_W-1:0] comp_idx;
    logic              frame_done;
    logic              err_timeout;
    logic              rst_marker_req;

    // Sequencer side.
    modport slave (
        input  blk_valid, blk_last, huffman_done,
        output blk_ready, input_enable, dct_enable, dct_end_enable, matrix_row,
               zigzag_input_enable, zigzag_enable, huffman_start, is_luminance,
               comp_idx, frame_done, err_timeout, rst_marker_req
    );

    // Host feeder / datapath side.
    modport master (
        output blk_valid, blk_last, huffman_done,
        input  blk_ready, input_enable, dct_enable, dct_end_enable, matrix_row,
               zigzag_input_enable, zigzag_enable, huffman_start, is_luminance,
               comp_idx, frame_done, err_timeout, rst_marker_req
    );
endinterface

// File: rtl/jpeg_block_sequencer.sv
// Per-block JPEG encoder control sequencer: LOAD/DCT/STORE/ROWS/ZIG/HSTART/HWAIT.
// Restart-marker requests are built only when JPEG_SEQ_RESTART_EN is defined.
module jpeg_block_sequencer #(
    parameter int unsigned NUM_COMP         = 3,
    parameter int unsigned Y_BLOCKS         = 1,
    parameter int unsigned DCT_LATENCY      = 4,
    parameter int unsigned QUANT_LATENCY    = 1,
    parameter int unsigned HUFF_TIMEOUT     = 1024,
    parameter int unsigned RESTART_INTERVAL = 0
) (
    input logic                    clock,
    input logic                    reset,
    jpeg_block_sequencer_if.slave  bus
);
    localparam int unsigned NumPos = Y_BLOCKS + NUM_COMP - 1;
    localparam int unsigned CompW  = $clog2(Y_BLOCKS + NUM_COMP);
    localparam int unsigned CntW   = $clog2(DCT_LATENCY + QUANT_LATENCY + 1);
    localparam int unsigned TmoW   = $clog2(HUFF_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle, StLoad, StDct, StStore, StRows, StZig, StHstart, StHwait
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        row_q, row_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [CompW-1:0]  comp_q, comp_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic              fd_q, fd_d;
    logic              block_done;

    logic              blk_ready, input_enable, dct_enable, dct_end_enable;
    logic              zigzag_input_enable, zigzag_enable, huffman_start;
    logic [7:0]        matrix_row;

`ifdef JPEG_SEQ_RESTART_EN
    localparam int unsigned McuW = 16;
    logic [McuW-1:0]   mcu_q, mcu_d;
    logic              rm_q, rm_d;
`else
    logic              unused_restart;
    assign unused_restart = (RESTART_INTERVAL != 0);
`endif

    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        row_d               = row_q;
        tmo_d               = tmo_q;
        comp_d              = comp_q;
        last_d              = last_q;
        err_d               = err_q;
        fd_d                = 1'b0;
        block_done          = 1'b0;
        blk_ready           = 1'b0;
        input_enable        = 1'b0;
        dct_enable          = 1'b0;
        dct_end_enable      = 1'b0;
        zigzag_input_enable = 1'b0;
        zigzag_enable       = 1'b0;
        huffman_start       = 1'b0;
        matrix_row          = 8'd0;
`ifdef JPEG_SEQ_RESTART_EN
        mcu_d               = mcu_q;
        rm_d                = 1'b0;
`endif

        case (state_q)
            StIdle: begin
                blk_ready = 1'b1;
                if (bus.blk_valid) begin
                    last_d  = bus.blk_last;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                input_enable = 1'b1;
                cnt_d        = '0;
                state_d      = StDct;
            end
            StDct: begin
                dct_enable = 1'b1;
                if (cnt_q == CntW'(DCT_LATENCY - 1)) begin
                    cnt_d   = '0;
                    state_d = StStore;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStore: begin
                dct_end_enable = 1'b1;
                cnt_d          = '0;
                row_d          = 3'd0;
                state_d        = StRows;
            end
            StRows: begin
                matrix_row = {5'd0, row_q};
                // The row write strobe lands once the quantiser pipeline has drained.
                if (cnt_q == CntW'(QUANT_LATENCY)) begin
                    zigzag_input_enable = 1'b1;
                    cnt_d               = '0;
                    if (row_q == 3'd7) begin
                        state_d = StZig;
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StZig: begin
                zigzag_enable = 1'b1;
                state_d       = StHstart;
            end
            StHstart: begin
                huffman_start = 1'b1;
                tmo_d         = '0;
                state_d       = StHwait;
            end
            StHwait: begin
                if (bus.huffman_done) begin
                    block_done = 1'b1;
                end else if (tmo_q == TmoW'(HUFF_TIMEOUT - 1)) begin
                    err_d      = 1'b1;
                    block_done = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (block_done) begin
            state_d = StIdle;
            tmo_d   = '0;
            fd_d    = last_q;
            if (last_q) begin
                // Frame end abandons any partial MCU.
                comp_d = '0;
`ifdef JPEG_SEQ_RESTART_EN
                mcu_d  = '0;
`endif
            end else if (comp_q == CompW'(NumPos - 1)) begin
                comp_d = '0;
`ifdef JPEG_SEQ_RESTART_EN
                if ((RESTART_INTERVAL != 0) &&
                    ((mcu_q + 16'd1) == McuW'(RESTART_INTERVAL))) begin
                    rm_d  = 1'b1;
                    mcu_d = '0;
                end else begin
                    mcu_d = mcu_q + 16'd1;
                end
`endif
            end else begin
                comp_d = comp_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            row_q   <= 3'd0;
            tmo_q   <= '0;
            comp_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            fd_q    <= 1'b0;
`ifdef JPEG_SEQ_RESTART_EN
            mcu_q   <= '0;
            rm_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            tmo_q   <= tmo_d;
            comp_q  <= comp_d;
            last_q  <= last_d;
            err_q   <= err_d;
            fd_q    <= fd_d;
`ifdef JPEG_SEQ_RESTART_EN
            mcu_q   <= mcu_d;
            rm_q    <= rm_d;
`endif
        end
    end

    assign bus.blk_ready           = blk_ready;
    assign bus.input_enable        = input_enable;
    assign bus.dct_enable          = dct_enable;
    assign bus.dct_end_enable      = dct_end_enable;
    assign bus.matrix_row          = matrix_row;
    assign bus.zigzag_input_enable = zigzag_input_enable;
    assign bus.zigzag_enable       = zigzag_enable;
    assign bus.huffman_start       = huffman_start;
    assign bus.is_luminance        = (comp_q < CompW'(Y_BLOCKS));
    assign bus.comp_idx            = comp_q;
    assign bus.frame_done          = fd_q;
    assign bus.err_timeout         = err_q;
`ifdef JPEG_SEQ_RESTART_EN
    assign bus.rst_marker_req      = rm_q;
`else
    assign bus.rst_marker_req      = 1'b0;
`endif
endmodule
